uart_tx_scheduler: RTL

Shares the single UART transmitter between NUM_REQ byte producers, e.g. the RX echo path and the switch-input/push-button path. It arbitrates round-robin, captures the winning byte, and launches one frame through the tx_start/tx_busy handshake. It owns the transmitter until the frame completes and reports completion per requester. It sits between the producers and the UART TX core inside the top-level UART_BCD design.

---
 rtl/uart_tx_scheduler_pkg.sv | 27 ++
 rtl/uart_tx_scheduler_rr_pick.sv | 43 ++++
 rtl/uart_tx_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler_pkg
// Shared definitions for the UART TX scheduler: FSM state encoding, default
// sizes and the round-robin pointer wrap helper.
// -----------------------------------------------------------------------------
package uart_tx_scheduler_pkg;

   typedef enum logic [1:0] {
      UTXS_IDLE      = 2'd0,
      UTXS_LAUNCH    = 2'd1,
      UTXS_WAIT_BUSY = 2'd2,
      UTXS_WAIT_DONE = 2'd3
   } utxs_state_e;

   localparam int unsigned UTXS_DATA_W_DEFAULT  = 32'd8;
   localparam int unsigned UTXS_NUM_REQ_DEFAULT = 32'd2;

   // Next round-robin position after idx, wrapping n-1 back to 0.
   function automatic int unsigned utxs_wrap_inc(input int unsigned idx, input int unsigned n);
      if (idx + 32'd1 >= n) begin
         return 32'd0;
      end else begin
         return idx + 32'd1;
      end
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler_rr_pick
// Purely combinational round-robin selector: the winner is the first asserted
// request at or after ptr_i, searching upward modulo NUM_REQ.
//   req_i   : request vector
//   ptr_i   : highest-priority index for this round
//   grant_o : one-hot winner (all zero when nothing requests)
//   idx_o   : encoded winner index
//   any_o   : at least one request asserted
// -----------------------------------------------------------------------------
module uart_tx_scheduler_rr_pick #(
   parameter int unsigned NUM_REQ = 32'd2,
   parameter int unsigned IDX_W   = 32'd1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   // Rotating priority search starting at ptr_i.
   always_comb begin
      logic [IDX_W-1:0] k;
      logic             found;
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      k       = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         k = IDX_W'((int'(ptr_i) + i) % int'(NUM_REQ));
         if (!found && req_i[k]) begin
            found      = 1'b1;
            grant_o[k] = 1'b1;
            idx_o      = k;
         end else begin
            found = found;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmitter between NUM_REQ byte producers. Arbitrates
// round-robin, captures the winning byte, launches one frame through the
// tx_start/tx_busy handshake and reports completion to the owner.
//
// Optional build macro: UART_TX_TIMEOUT_EN adds a watchdog that abandons a
// frame after TIMEOUT_CYCLES cycles in WAIT_BUSY/WAIT_DONE.
//
// Ports:
//   src_clk_i    : system clock
//   rst_i        : asynchronous active-high reset
//   req_valid_i  : per-requester byte available
//   req_data_i   : packed bytes, requester k at [k*DATA_W +: DATA_W]
//   req_ready_o  : one-hot accept, combinational, only in IDLE
//   req_done_o   : one-cycle pulse to the owner when its frame finishes
//   tx_start_o   : one-cycle launch pulse to the TX core
//   tx_data_o    : byte to the TX core, stable from launch until IDLE
//   tx_busy_i    : TX core is shifting a frame
//   grant_id_o   : index of the current or last owner
//   tx_timeout_o : one-cycle watchdog pulse (constant 0 without the macro)
// -----------------------------------------------------------------------------
module uart_tx_scheduler
   import uart_tx_scheduler_pkg::*;
#(
   parameter int unsigned NUM_REQ        = UTXS_NUM_REQ_DEFAULT,
   parameter int unsigned DATA_W         = UTXS_DATA_W_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 32'd600000,
   localparam int unsigned IDX_W         = (NUM_REQ > 32'd1) ? $clog2(NUM_REQ) : 32'd1
) (
   input  logic                      src_clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   output logic [NUM_REQ-1:0]        req_done_o,
   output logic                      tx_start_o,
   output logic [DATA_W-1:0]         tx_data_o,
   input  logic                      tx_busy_i,
   output logic [IDX_W-1:0]          grant_id_o,
   output logic                      tx_timeout_o
);

   utxs_state_e        state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [DATA_W-1:0]  tx_data_q, tx_data_d;
   logic [IDX_W-1:0]   grant_id_q, grant_id_d;
   logic [NUM_REQ-1:0] pick_grant;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic [IDX_W-1:0]   next_ptr;
   logic               timeout_hit;

   uart_tx_scheduler_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req_i   (req_valid_i),
      .ptr_i   (rr_ptr_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   // Priority moves to the requester just after the one that owned the TX.
   assign next_ptr = IDX_W'(utxs_wrap_inc(32'(grant_id_q), NUM_REQ));

`ifdef UART_TX_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);
   logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

   // Watchdog count: zero on the first WAIT_BUSY cycle, +1 per waiting cycle.
   always_comb begin
      if (state_q == UTXS_LAUNCH) begin
         wd_cnt_d = '0;
      end else if (state_q == UTXS_WAIT_BUSY || state_q == UTXS_WAIT_DONE) begin
         wd_cnt_d = wd_cnt_q + CNT_W'(1);
      end else begin
         wd_cnt_d = wd_cnt_q;
      end
   end

   // Watchdog counter register.
   always_ff @(posedge src_clk_i or posedge rst_i) begin
      if (rst_i) begin
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
      end
   end

   assign timeout_hit = (state_q == UTXS_WAIT_BUSY || state_q == UTXS_WAIT_DONE) &&
                        (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state and handshake outputs.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      tx_data_d    = tx_data_q;
      grant_id_d   = grant_id_q;
      req_ready_o  = '0;
      req_done_o   = '0;
      tx_start_o   = 1'b0;
      tx_timeout_o = 1'b0;
      case (state_q)
         UTXS_IDLE: begin
            req_ready_o = pick_grant;
            if (pick_any) begin
               tx_data_d  = req_data_i[pick_idx*DATA_W +: DATA_W];
               grant_id_d = pick_idx;
               state_d    = UTXS_LAUNCH;
            end else begin
               state_d = UTXS_IDLE;
            end
         end
         UTXS_LAUNCH: begin
            tx_start_o = 1'b1;
            state_d    = UTXS_WAIT_BUSY;
         end
         UTXS_WAIT_BUSY: begin
            if (timeout_hit) begin
               tx_timeout_o = 1'b1;
               rr_ptr_d     = next_ptr;
               state_d      = UTXS_IDLE;
            end else if (tx_busy_i) begin
               state_d = UTXS_WAIT_DONE;
            end else begin
               state_d = UTXS_WAIT_BUSY;
            end
         end
         UTXS_WAIT_DONE: begin
            // A genuine completion wins over a coincident watchdog expiry.
            if (!tx_busy_i) begin
               req_done_o[grant_id_q] = 1'b1;
               rr_ptr_d               = next_ptr;
               state_d                = UTXS_IDLE;
            end else if (timeout_hit) begin
               tx_timeout_o = 1'b1;
               rr_ptr_d     = next_ptr;
               state_d      = UTXS_IDLE;
            end else begin
               state_d = UTXS_WAIT_DONE;
            end
         end
         default: begin
            state_d = UTXS_IDLE;
         end
      endcase
   end

   // State, pointer and captured-byte registers.
   always_ff @(posedge src_clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= UTXS_IDLE;
         rr_ptr_q   <= '0;
         tx_data_q  <= '0;
         grant_id_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         tx_data_q  <= tx_data_d;
         grant_id_q <= grant_id_d;
      end
   end

   assign tx_data_o  = tx_data_q;
   assign grant_id_o = grant_id_q;

endmodule
